fft_loader: RTL and testbench



---
 rtl/fft_loader.sv | 135 +++++++++++++
 tb/tb_fft_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fft_loader.sv
// fft_loader: writer side of the FFT working memory.
// Takes a valid/ready stream of real ADC samples and sign-extends each one
// into a {re, im} word. It writes that word to the bit-reversed address of
// the sample index. After a full frame it pulses fft_start, then stalls
// input until the FFT reports done.
//
// state | meaning
// LOAD  | accepting samples, one RAM write per accept
// START | last write on the bus; fft_start pulses next cycle
// WAIT  | frame handed to the FFT, input stalled until fft_done
module fft_loader #(
  parameter int width = 16,
  parameter int nlog2 = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [width-6:0]     sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 we,
  output logic [nlog2-1:0]     adr,
  output logic [2*width-1:0]   wd,
  output logic                 fft_start,
  input  logic                 fft_done,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

  state_t               state_q, state_d;
  logic [nlog2-1:0]     count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [nlog2-1:0]     adr_q, adr_d;
  logic [2*width-1:0]   wd_q, wd_d;
  logic                 fft_start_q, fft_start_d;
  logic [15:0]          drop_q, drop_d;

  logic                 accept;
  logic                 last_idx;
  logic [nlog2-1:0]     count_rev;

  assign accept   = sample_valid & ready_q;
  assign last_idx = &count_q;

  // Bit-reverse the sample index to get the RAM address
  always_comb begin
    count_rev = '0;
    for (int i = 0; i < nlog2; i++) begin
      count_rev[i] = count_q[nlog2-1-i];
    end
  end

  // Next-state and registered-output logic for the frame FSM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ready_d     = ready_q;
    we_d        = 1'b0;
    adr_d       = adr_q;
    wd_d        = wd_q;
    fft_start_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        ready_d = 1'b1;
        if (accept) begin
          we_d    = 1'b1;
          adr_d   = count_rev;
          // re half carries the sign-extended sample, im half is zero
          wd_d    = {{5{sample_in[width-6]}}, sample_in, {width{1'b0}}};
          count_d = count_q + nlog2'(1);
          if (last_idx) begin
            ready_d = 1'b0;
            state_d = START;
          end
        end
      end
      START: begin
        ready_d     = 1'b0;
        fft_start_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        ready_d = 1'b0;
        if (fft_done) begin
          ready_d = 1'b1;
          state_d = LOAD;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = LOAD;
      end
    endcase
  end

  // Saturating count of samples offered while stalled
  always_comb begin
    drop_d = drop_q;
    if (sample_valid && !ready_q && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      count_q     <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wd_q        <= '0;
      fft_start_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wd_q        <= wd_d;
      fft_start_q <= fft_start_d;
      drop_q      <= drop_d;
    end
  end

  assign sample_ready = ready_q;
  assign we           = we_q;
  assign adr          = adr_q;
  assign wd           = wd_q;
  assign fft_start    = fft_start_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader: full frames (continuous and gapped),
// sign extension, stall/drop counting, restart on fft_done, mid-frame reset.
module tb_fft_loader;

  localparam int W  = 16;
  localparam int NL = 11;
  localparam int N  = 2048;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-6:0]    sample_in;
  logic            sample_valid;
  logic            sample_ready;
  logic            we;
  logic [NL-1:0]   adr;
  logic [2*W-1:0]  wd;
  logic            fft_start;
  logic            fft_done;
  logic [15:0]     drop_cnt;

  int errors = 0;
  int checks = 0;
  int nwrites;

  fft_loader #(.width(W), .nlog2(NL)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .we           (we),
    .adr          (adr),
    .wd           (wd),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL-1:0] brev(input int idx);
    logic [NL-1:0] v, r;
    v = idx[NL-1:0];
    for (int b = 0; b < NL; b++) r[b] = v[NL-1-b];
    return r;
  endfunction

  function automatic logic [2*W-1:0] sext_word(input logic [W-6:0] s);
    return {{5{s[W-6]}}, s, 16'h0000};
  endfunction

  // One accept of sample index idx; checks the write presented next cycle
  task automatic accept_one(input int idx, input logic [W-6:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    check("we_on_accept", {31'b0, we}, 32'd1);
    check("adr_bitrev", {21'b0, adr}, {21'b0, brev(idx)});
    check("wd_sext", wd, sext_word(s));
    check("no_start_in_load", {31'b0, fft_start}, 32'd0);
    check("ready_after_accept", {31'b0, sample_ready}, (idx == N-1) ? 32'd0 : 32'd1);
    if (we) nwrites++;
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; fft_done = 1'b0;
    repeat (3) tick();
    check("rst_ready", {31'b0, sample_ready}, 32'd0);
    check("rst_we", {31'b0, we}, 32'd0);
    check("rst_adr", {21'b0, adr}, 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_start", {31'b0, fft_start}, 32'd0);
    check("rst_drop", {16'b0, drop_cnt}, 32'd0);

    // Frame 1: valid held high; first post-reset cycle counts as a drop
    reset = 1'b0; sample_valid = 1'b1;
    tick();
    check("ready_first_cycle", {31'b0, sample_ready}, 32'd1);
    check("drop_first_cycle", {16'b0, drop_cnt}, 32'd1);
    nwrites = 0;
    for (int i = 0; i < N; i++) begin
      accept_one(i, i[W-6:0]);
      if (i == 1)     check("adr_idx1", {21'b0, adr}, 32'd1024);
      if (i == 2)     check("adr_idx2", {21'b0, adr}, 32'd512);
      if (i == 3)     check("adr_idx3", {21'b0, adr}, 32'd1536);
      if (i == 'h3FF) check("sext_3ff", wd, 32'h03FF0000);
      if (i == 'h400) check("sext_400", wd, 32'hFC000000);
      if (i == 'h7FF) check("sext_7ff", wd, 32'hFFFF0000);
    end
    check("frame1_writes", nwrites, N);
    check("last_adr", {21'b0, adr}, 32'd2047);
    tick();
    check("start_pulse", {31'b0, fft_start}, 32'd1);
    check("start_no_we", {31'b0, we}, 32'd0);
    tick();
    check("start_single", {31'b0, fft_start}, 32'd0);
    check("drop_after_frame1", {16'b0, drop_cnt}, 32'd3);

    // WAIT with fft_done low for 100 cycles, valid still high
    for (int k = 0; k < 100; k++) begin
      tick();
      check("wait_ready_low", {31'b0, sample_ready}, 32'd0);
      check("wait_we_low", {31'b0, we}, 32'd0);
      check("wait_no_start", {31'b0, fft_start}, 32'd0);
    end
    check("drop_plus_100", {16'b0, drop_cnt}, 32'd103);

    // fft_done held 3 cycles restarts exactly one frame
    sample_valid = 1'b0; fft_done = 1'b1;
    tick();
    check("ready_after_done", {31'b0, sample_ready}, 32'd1);
    tick();
    tick();
    check("ready_done_held", {31'b0, sample_ready}, 32'd1);
    check("no_start_done_held", {31'b0, fft_start}, 32'd0);
    fft_done = 1'b0;

    // Frame 2: valid 1 of every 3 cycles
    nwrites = 0;
    for (int i = 0; i < N; i++) begin
      accept_one(i, ~i[W-6:0]);
      sample_valid = 1'b0;
      tick();
      check("gap1_we", {31'b0, we}, 32'd0);
      check("gap1_adr_hold", {21'b0, adr}, {21'b0, brev(i)});
      check("gap1_start", {31'b0, fft_start}, (i == N-1) ? 32'd1 : 32'd0);
      tick();
      check("gap2_we", {31'b0, we}, 32'd0);
      check("gap2_start", {31'b0, fft_start}, 32'd0);
      check("gap2_ready", {31'b0, sample_ready}, (i == N-1) ? 32'd0 : 32'd1);
    end
    check("frame2_writes", nwrites, N);
    check("drop_gapped", {16'b0, drop_cnt}, 32'd103);
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("ready_frame3", {31'b0, sample_ready}, 32'd1);

    // Frame 3: reset after 700 accepts
    for (int i = 0; i < 700; i++) accept_one(i, i[W-6:0] ^ 11'h2A5);
    sample_valid = 1'b0; reset = 1'b1;
    tick();
    check("mid_rst_ready", {31'b0, sample_ready}, 32'd0);
    check("mid_rst_we", {31'b0, we}, 32'd0);
    check("mid_rst_adr", {21'b0, adr}, 32'd0);
    check("mid_rst_wd", wd, 32'd0);
    check("mid_rst_start", {31'b0, fft_start}, 32'd0);
    check("mid_rst_drop", {16'b0, drop_cnt}, 32'd0);

    // Full frame again, with fft_done high during early LOAD
    reset = 1'b0; sample_valid = 1'b1; fft_done = 1'b1;
    tick();
    check("ready_post_rst", {31'b0, sample_ready}, 32'd1);
    check("drop_post_rst", {16'b0, drop_cnt}, 32'd1);
    nwrites = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 10) fft_done = 1'b0;
      accept_one(i, i[W-6:0] ^ 11'h155);
    end
    check("frame4_writes", nwrites, N);
    tick();
    check("start_frame4", {31'b0, fft_start}, 32'd1);
    sample_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("one_start_only", {31'b0, fft_start}, 32'd0);
      check("ready_wait4", {31'b0, sample_ready}, 32'd0);
    end
    check("drop_frame4", {16'b0, drop_cnt}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
